// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic array: holds A and B, then streams
// A rows and B columns onto the array edges with per-lane diagonal skew.
module systolic_feeder #(
   parameter int DATAWIDTH = 16,
   parameter int N         = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [$clog2(N)-1:0]   wr_row,
   input  logic [$clog2(N)-1:0]   wr_col,
   input  logic [DATAWIDTH-1:0]   wr_data,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [N*DATAWIDTH-1:0] a_edge,
   output logic [N-1:0]           a_valid,
   output logic [N*DATAWIDTH-1:0] b_edge,
   output logic [N-1:0]           b_valid
);

   localparam int TW = $clog2(3*N-2);
   localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] t_q, t_d;
   logic          accept_start;
   logic          wr_ok;

   logic [DATAWIDTH-1:0] a_mem_q [N][N];
   logic [DATAWIDTH-1:0] b_mem_q [N][N];

   logic [DATAWIDTH-1:0] a_lane_d [N];
   logic [DATAWIDTH-1:0] b_lane_d [N];
   logic [N-1:0]         a_valid_d, b_valid_d;

   logic                   busy_q, done_q;
   logic [N*DATAWIDTH-1:0] a_edge_q, b_edge_q;
   logic [N-1:0]           a_valid_q, b_valid_q;

   always_comb begin
      state_d      = state_q;
      t_d          = t_q;
      accept_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            t_d = '0;
            if (start) begin
               accept_start = 1'b1;
               state_d      = S_STREAM;
            end
         end
         S_STREAM: begin
            if (t_q == T_LAST) begin
               state_d = S_DONE;
               t_d     = '0;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         S_DONE: begin
            t_d = '0;
            if (start) begin
               accept_start = 1'b1;
               state_d      = S_STREAM;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            t_d     = '0;
         end
      endcase
   end

   // A start in the same cycle as a write wins; the write is dropped.
   assign wr_ok = wr_en && !accept_start &&
                  (state_q == S_IDLE || state_q == S_DONE);

   // Outputs are registered from the next step so step t shows after edge E0+t.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_lane_d[i]  = '0;
         b_lane_d[i]  = '0;
         a_valid_d[i] = 1'b0;
         b_valid_d[i] = 1'b0;
         if (state_d == S_STREAM) begin
            for (int k = 0; k < N; k++) begin
               if (int'(t_d) == i + k) begin
                  a_valid_d[i] = 1'b1;
                  a_lane_d[i]  = a_mem_q[i][k];
                  b_valid_d[i] = 1'b1;
                  b_lane_d[i]  = b_mem_q[k][i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         t_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         a_edge_q  <= '0;
         b_edge_q  <= '0;
         a_valid_q <= '0;
         b_valid_q <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         busy_q    <= (state_d == S_STREAM);
         done_q    <= (state_d == S_DONE);
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         for (int i = 0; i < N; i++) begin
            a_edge_q[i*DATAWIDTH +: DATAWIDTH] <= a_lane_d[i];
            b_edge_q[i*DATAWIDTH +: DATAWIDTH] <= b_lane_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_mem_q[r][c] <= '0;
               b_mem_q[r][c] <= '0;
            end
         end
      end else if (wr_ok) begin
         if (wr_sel) begin
            b_mem_q[wr_row][wr_col] <= wr_data;
         end else begin
            a_mem_q[wr_row][wr_col] <= wr_data;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign a_edge  = a_edge_q;
   assign b_edge  = b_edge_q;
   assign a_valid = a_valid_q;
   assign b_valid = b_valid_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: pass-level model compared every cycle,
// plus directed literal checks on skew, controls, reset and back-to-back.
module tb_systolic_feeder;

   localparam int DW      = 16;
   localparam int N       = 4;
   localparam int T_STEPS = 3*N-2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [1:0]    wr_row = '0;
   logic [1:0]    wr_col = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [N*DW-1:0] a_edge, b_edge;
   logic [N-1:0]    a_valid, b_valid;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   systolic_feeder #(.DATAWIDTH(DW), .N(N)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .start(start), .busy(busy), .done(done),
      .a_edge(a_edge), .a_valid(a_valid),
      .b_edge(b_edge), .b_valid(b_valid)
   );

   // Model: ph = cycles since the accepted start (-1 when idle).
   logic [DW-1:0]   ma [N][N];
   logic [DW-1:0]   mb [N][N];
   int              ph = -1;
   logic            e_busy = 1'b0, e_done = 1'b0;
   logic [N-1:0]    e_av = '0, e_bv = '0;
   logic [N*DW-1:0] e_ae = '0, e_be = '0;

   always @(posedge clk) begin
      bit open, go;
      int d;
      if (rst) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               ma[r][c] = '0;
               mb[r][c] = '0;
            end
         ph = -1;
      end else begin
         open = (ph < 0) || (ph == T_STEPS);
         go   = open && start;
         if (open && !go && wr_en) begin
            if (wr_sel) mb[wr_row][wr_col] = wr_data;
            else        ma[wr_row][wr_col] = wr_data;
         end
         if (go) ph = 0;
         else if (ph >= 0 && ph < T_STEPS) ph++;
         else ph = -1;
      end
      e_busy = (ph >= 0) && (ph < T_STEPS);
      e_done = (ph == T_STEPS);
      e_av = '0; e_bv = '0; e_ae = '0; e_be = '0;
      for (int i = 0; i < N; i++) begin
         d = ph - i;
         if (e_busy && d >= 0 && d < N) begin
            e_av[i] = 1'b1;
            e_bv[i] = 1'b1;
            e_ae[i*DW +: DW] = ma[i][d];
            e_be[i*DW +: DW] = mb[d][i];
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if ({busy, done, a_valid, b_valid, a_edge, b_edge} !==
             {e_busy, e_done, e_av, e_bv, e_ae, e_be}) begin
            errors++;
            $display("FAIL model @%0t busy=%b/%b done=%b/%b av=%h/%h bv=%h/%h ae=%h/%h be=%h/%h",
                     $time, busy, e_busy, done, e_done, a_valid, e_av,
                     b_valid, e_bv, a_edge, e_ae, b_edge, e_be);
         end
      end
   end

   function automatic logic [DW-1:0] alane(input int i);
      return a_edge[i*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] blane(input int i);
      return b_edge[i*DW +: DW];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wr(input bit sel, input int r, input int c,
                     input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = 2'(r);
      wr_col  = 2'(c);
      wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 40) begin
         cyc();
         n++;
      end
      chk("idle_timeout", 32'(n < 40), 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         cyc();
         n++;
      end
      chk("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int nb;
      cyc();
      cyc();
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("rst_av", 32'(a_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ae", 32'(a_edge), 32'd0);

      // Skew and order
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            wr(1'b0, r, c, DW'(4*r + c + 1));
      for (int i = 0; i < N; i++) wr(1'b1, i, i, 16'd1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      nb = 0;
      for (int t = 0; t < T_STEPS; t++) begin
         if (busy) nb++;
         if (t < 4) chk("a0_seq", 32'(alane(0)), 32'(t + 1));
         if (t >= 3 && t <= 6) begin
            chk("a3_val", 32'(a_valid[3]), 32'd1);
            chk("a3_seq", 32'(alane(3)), 32'(13 + t - 3));
         end else begin
            chk("a3_inv", 32'(a_valid[3]), 32'd0);
            chk("a3_zero", 32'(alane(3)), 32'd0);
         end
         if (t >= 2 && t <= 5) chk("b2_seq", 32'(blane(2)), 32'(t == 4));
         cyc();
      end
      chk("busy_cnt", 32'(nb), 32'd10);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      cyc();
      chk("done_once", 32'(done), 32'd0);

      // Ignored controls during STREAM
      wait_idle();
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int t = 0; t < T_STEPS; t++) begin
         if (t == 4) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_row  = 2'd0;
            wr_col  = 2'd0;
            wr_data = 16'hAAAA;
         end else begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         cyc();
      end
      start = 1'b0;
      wr_en = 1'b0;
      chk("ign_done", 32'(done), 32'd1);
      wait_idle();
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("old_a00", 32'(alane(0)), 32'd1);
      wait_idle();

      // Simultaneous start and write
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_row  = 2'd1;
      wr_col  = 2'd1;
      wr_data = 16'h0055;
      start   = 1'b1;
      cyc();
      wr_en = 1'b0;
      start = 1'b0;
      cyc();
      cyc();
      chk("sim_a1_val", 32'(a_valid[1]), 32'd1);
      chk("sim_a1", 32'(alane(1)), 32'd6);

      // Back-to-back
      wait_done();
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done", 32'(done), 32'd0);
      chk("b2b_av", 32'(a_valid), 32'd1);
      chk("b2b_a0", 32'(alane(0)), 32'd1);
      wait_idle();

      // Reset mid-stream
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mr_av", 32'(a_valid), 32'd0);
      chk("mr_bv", 32'(b_valid), 32'd0);
      chk("mr_ae", 32'(a_edge), 32'd0);
      chk("mr_be", 32'(b_edge), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (3) cyc();
      chk("mr2_av", 32'(a_valid), 32'hF);
      chk("mr2_bv", 32'(b_valid), 32'hF);
      chk("mr2_ae", 32'(a_edge), 32'd0);
      wait_idle();

      // Full scale
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            wr(1'b0, r, c, (r == 3 && c == 0) ? 16'h0000 : 16'hFFFF);
            wr(1'b1, r, c, 16'hFFFF);
         end
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (3) cyc();
      chk("fs_a3_val", 32'(a_valid[3]), 32'd1);
      chk("fs_a3", 32'(alane(3)), 32'd0);
      chk("fs_a0", 32'(alane(0)), 32'hFFFF);
      chk("fs_b0", 32'(blane(0)), 32'hFFFF);
      wait_idle();

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the N×N systolic PE array. It stores one A matrix and one B matrix written through a simple write port. On `start`, it streams them into the array edges with the diagonal skew the PEs need: row i of A enters the left edge on lane i delayed by i cycles, and column j of B enters the top edge on lane j delayed by j cycles. Each lane has its own valid bit so edge PEs accumulate only real operands.

## Interface
- `DATAWIDTH`, 16, operand width (matches PE `a_in`/`b_in`)
- `N`, 4, array dimension; number of A lanes and B lanes
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `wr_en` in 1: write one matrix element this cycle
- `wr_sel` in 1: 0 = A, 1 = B
- `wr_row` in $clog2(N): element row index
- `wr_col` in $clog2(N): element column index
- `wr_data` in DATAWIDTH: element value
- `start` in 1: begin one streaming pass
- `busy` out 1: high while streaming
- `done` out 1: one-cycle pulse after the last stream step
- `a_edge` out N*DATAWIDTH: lane i at bits [i*DATAWIDTH +: DATAWIDTH], drives `a_in` of row-i left PE
- `a_valid` out N: bit i is the valid for A lane i
- `b_edge` out N*DATAWIDTH: lane j drives `b_in` of column-j top PE
- `b_valid` out N: bit j is the valid for B lane j

## Operation
- Storage: two N×N register arrays, `A[r][c]` and `B[r][c]`, each DATAWIDTH wide.
- FSM states IDLE, STREAM, DONE.
  - IDLE: accepts writes. `start` goes to STREAM with step counter t=0.
  - STREAM: t increments every cycle from 0 to 3N-3. At t=3N-3 the next state is DONE.
  - DONE: lasts one cycle. `start` in DONE goes to STREAM with t=0 (back-to-back passes allowed); otherwise the next state is IDLE.
- Stream step t, all outputs registered:
  - A lane i: `a_valid[i]` = 1 if and only if 0 ≤ t-i < N; the lane data is `A[i][t-i]`.
  - B lane j: `b_valid[j]` = 1 if and only if 0 ≤ t-j < N; the lane data is `B[t-j][j]`.
  - Any lane with valid low drives data 0.
- Writes are committed only in IDLE or DONE. `wr_en` during STREAM is dropped.
- `wr_en` and an accepted `start` in the same cycle: `start` is accepted and the write is dropped.
- `start` during STREAM is ignored.
- Data is passed bit-exact; no arithmetic on operands. t counter width is $clog2(3N-2).
- The feeder never clears the PE accumulators. Clearing the array between passes belongs to the array wrapper.

## Timing
- Reset (`rst` high at a clock edge) has this effect after the edge:
  - state IDLE, t=0
  - `busy`=0, `done`=0
  - `a_valid`=0, `b_valid`=0
  - `a_edge`=0, `b_edge`=0
  - both matrix stores cleared to 0
- Reset has priority over `start` and `wr_en`, and applies mid-stream with the same result. No partial lane stays valid.
- `start` sampled at edge E0:
  - step t appears on the outputs during the cycle after edge E0+t.
  - `busy` is high for the 3N-2 cycles after E0 through E0+3N-3.
  - `done` is high for the single cycle after E0+3N-2, with `busy` low in that cycle.
- A write at edge E is visible to a pass started at any edge after E.
- Lane i valid window: cycles t=i through t=i+N-1, which is exactly N valid cycles per lane.
- Full pass: 3N-2 stream cycles plus 1 done cycle.

## Test plan
- **Skew and order (N=4):**
  - Stimulus: A[r][c]=4r+c+1, B=identity, `start`.
  - Lane 0 shows `a_edge` 1,2,3,4 at t=0..3.
  - Lane 3 is valid only at t=3..6, showing 13,14,15,16.
  - `b_edge` lane 2 shows 0,0,1,0 at t=2..5.
  - All invalid lanes drive 0.
  - `busy` is high for 10 cycles, then `done` pulses once.
- **Reset mid-stream:**
  - Stimulus: assert `rst` at t=5.
  - Next cycle: all valids 0, all data 0, `busy`=0, `done`=0.
  - A following pass streams all-zero data with the normal valid pattern.
- **Ignored controls:**
  - `start` at t=4: no restart, `done` still pulses 10 cycles after the original start.
  - `wr_en` of A[0][0]=0xAAAA during STREAM: the next pass emits the old A[0][0].
- **Simultaneous start and write in IDLE:**
  - Stimulus: write A[1][1]=0x0055 in the same cycle as `start`.
  - The pass is accepted, the write is dropped, and lane 1 at t=2 emits the old value.
- **Back-to-back:**
  - `start` held high across the DONE cycle launches a second pass.
  - The new t=0 appears in the cycle after `done`, with no idle gap.
- **Full scale:**
  - All elements 0xFFFF, plus one element of 0x0000 at A[3][0].
  - Values pass unchanged.
  - `a_valid[3]` is high with data 0x0000 at t=3.
